// File: rtl/alu_pipe_if.sv
// Operand/result handshake bundle for alu_pipe.
// Latency: none (wires only).
// Backpressure: in_ready/out_ready carry valid/ready backpressure in each direction.
// Ports: in_valid/in_ready/src1/src2/op on the operand side;
//        out_valid/out_ready/dst/zero/neg/carry/ovf on the result side.
// master drives operands and out_ready; slave (the ALU) drives in_ready and results.
interface alu_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] dst;
  logic             zero;
  logic             neg;
  logic             carry;
  logic             ovf;

  modport master (
    output in_valid, src1, src2, op, out_ready,
    input  in_ready, out_valid, dst, zero, neg, carry, ovf
  );

  modport slave (
    input  in_valid, src1, src2, op, out_ready,
    output in_ready, out_valid, dst, zero, neg, carry, ovf
  );
endinterface

// File: rtl/alu_pipe.sv
// Registered WIDTH-bit ALU (ADD/SUB/SHL/PASS/AND/OR/XOR/NOT) with NZCV flags.
// Latency: STAGES cycles (1 or 2) from operand acceptance to out_valid; 1 beat/cycle throughput.
// Backpressure: in_ready falls only when every slot is full and out_ready is low; held results stay stable.
// Ports: clk, rst_n (synchronous, active low), bus (alu_pipe_if.slave: operand and result handshakes).
// Optional feature macro: ALU_SAT_EN -- ADD/SUB saturate on signed overflow instead of wrapping.
module alu_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_pipe_if.slave  bus
);

  typedef struct packed {
    logic [WIDTH-1:0] dst;
    logic             zero;
    logic             neg;
    logic             carry;
    logic             ovf;
  } res_t;

  // Arithmetic runs at WIDTH+1 bits so bit WIDTH is the carry (or NOT-borrow for SUB).
  function automatic res_t alu_eval(input logic [WIDTH-1:0] a,
                                    input logic [WIDTH-1:0] b,
                                    input logic [2:0]       opc);
    logic [WIDTH:0] ext;
    res_t           r;
    ext = '0;
    r   = '0;
    case (opc)
      3'b000: begin
        ext     = {1'b0, a} + {1'b0, b};
        r.carry = ext[WIDTH];
        r.ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (ext[WIDTH-1] != a[WIDTH-1]);
      end
      3'b001: begin
        ext     = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
        r.carry = ext[WIDTH];
        r.ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (ext[WIDTH-1] != a[WIDTH-1]);
      end
      3'b010: begin
        ext     = {a, 1'b0};
        r.carry = ext[WIDTH];
      end
      3'b011:  ext = {1'b0, a};
      3'b100:  ext = {1'b0, a & b};
      3'b101:  ext = {1'b0, a | b};
      3'b110:  ext = {1'b0, a ^ b};
      default: ext = {1'b0, ~a};
    endcase
    r.dst = ext[WIDTH-1:0];
`ifdef ALU_SAT_EN
    // On overflow the true result has a's sign: clamp towards it.
    if (r.ovf) begin
      r.dst = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`else
`endif
    r.zero = (r.dst == '0);
    r.neg  = r.dst[WIDTH-1];
    return r;
  endfunction

  res_t res_q;
  logic out_valid_q;
  logic out_adv;  // result slot is empty or being drained this cycle

  assign out_adv       = !out_valid_q || bus.out_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.dst       = res_q.dst;
  assign bus.zero      = res_q.zero;
  assign bus.neg       = res_q.neg;
  assign bus.carry     = res_q.carry;
  assign bus.ovf       = res_q.ovf;

  if (STAGES == 1) begin : g_one_stage
    assign bus.in_ready = out_adv;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        out_valid_q <= 1'b0;
        res_q       <= '0;
      end else if (bus.in_valid && out_adv) begin
        // Covers pop+push in the same cycle: the new result replaces the old one.
        res_q       <= alu_eval(bus.src1, bus.src2, bus.op);
        out_valid_q <= 1'b1;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end else begin : g_two_stage
    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [2:0]       s1_op;
    logic             s1_adv;

    assign s1_adv       = !s1_valid || out_adv;
    assign bus.in_ready = s1_adv;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        s1_valid <= 1'b0;
        s1_a     <= '0;
        s1_b     <= '0;
        s1_op    <= '0;
      end else if (bus.in_valid && s1_adv) begin
        s1_valid <= 1'b1;
        s1_a     <= bus.src1;
        s1_b     <= bus.src2;
        s1_op    <= bus.op;
      end else if (out_adv) begin
        // Stage-1 content (if any) moves into the result register this edge.
        s1_valid <= 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        out_valid_q <= 1'b0;
        res_q       <= '0;
      end else if (s1_valid && out_adv) begin
        res_q       <= alu_eval(s1_a, s1_b, s1_op);
        out_valid_q <= 1'b1;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule
